// File: rtl/seq_mult.sv
// seq_mult: sequential signed radix-2 shift-add multiplier.
// Operands are converted to unsigned magnitudes, multiplied over B_WIDTH
// iterations, then the sign is applied in a final cycle.
// Optional build macro: SEQ_MULT_EARLY_TERM_EN - leave CALC as soon as the
// remaining multiplier magnitude is zero (variable latency, same results).
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   valid_in     operand pair valid, sampled while ready=1
//   multiplicand signed operand a [A_WIDTH]
//   multiplier   signed operand b [B_WIDTH]
//   ready        high only in IDLE
//   product      registered low OUT_WIDTH bits of a*b
//   valid_out    one-cycle pulse, product valid
//   overflow     a*b not representable in OUT_WIDTH signed bits
module seq_mult #(
    parameter int unsigned A_WIDTH   = 32,
    parameter int unsigned B_WIDTH   = 32,
    parameter int unsigned OUT_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic [A_WIDTH-1:0]   multiplicand,
    input  logic [B_WIDTH-1:0]   multiplier,
    output logic                 ready,
    output logic [OUT_WIDTH-1:0] product,
    output logic                 valid_out,
    output logic                 overflow
);

    localparam int unsigned P_W   = A_WIDTH + B_WIDTH;
    localparam int unsigned CNT_W = $clog2(B_WIDTH + 1);
    localparam int unsigned HI_W  = P_W - OUT_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    state_t               r_state;
    logic [P_W-1:0]       r_ma;
    logic [B_WIDTH-1:0]   r_mb;
    logic                 r_neg;
    logic [P_W-1:0]       r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [OUT_WIDTH-1:0] r_product;
    logic                 r_overflow;
    logic                 r_valid_out;

    state_t               w_state_nxt;
    logic [P_W-1:0]       w_ma_nxt;
    logic [B_WIDTH-1:0]   w_mb_nxt;
    logic                 w_neg_nxt;
    logic [P_W-1:0]       w_acc_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [OUT_WIDTH-1:0] w_product_nxt;
    logic                 w_overflow_nxt;
    logic                 w_valid_nxt;

    logic [A_WIDTH-1:0]   w_a_abs;
    logic [B_WIDTH-1:0]   w_b_abs;
    logic [P_W-1:0]       w_full;
    logic [HI_W-1:0]      w_upper;

    // Magnitudes held unsigned so the most negative operand negates exactly.
    assign w_a_abs = multiplicand[A_WIDTH-1] ? (~multiplicand + A_WIDTH'(1)) : multiplicand;
    assign w_b_abs = multiplier[B_WIDTH-1]   ? (~multiplier   + B_WIDTH'(1)) : multiplier;

    // Signed full-width product; overflow when bits above OUT_WIDTH-1 are not
    // all copies of the output sign bit.
    assign w_full  = r_neg ? (~r_acc + P_W'(1)) : r_acc;
    assign w_upper = w_full[P_W-1:OUT_WIDTH-1];

    assign ready     = (r_state == S_IDLE);
    assign product   = r_product;
    assign valid_out = r_valid_out;
    assign overflow  = r_overflow;

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt    = r_state;
        w_ma_nxt       = r_ma;
        w_mb_nxt       = r_mb;
        w_neg_nxt      = r_neg;
        w_acc_nxt      = r_acc;
        w_cnt_nxt      = r_cnt;
        w_product_nxt  = r_product;
        w_overflow_nxt = r_overflow;
        w_valid_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (valid_in) begin
                    w_ma_nxt    = P_W'(w_a_abs);
                    w_mb_nxt    = w_b_abs;
                    w_neg_nxt   = multiplicand[A_WIDTH-1] ^ multiplier[B_WIDTH-1];
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
`ifdef SEQ_MULT_EARLY_TERM_EN
                if (r_mb == '0) begin
                    w_state_nxt = S_SIGN;
                end else begin
`else
                begin
`endif
                    if (r_mb[0]) begin
                        w_acc_nxt = r_acc + r_ma;
                    end
                    w_ma_nxt  = r_ma << 1;
                    w_mb_nxt  = r_mb >> 1;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(B_WIDTH - 1)) begin
                        w_state_nxt = S_SIGN;
                    end
                end
            end
            S_SIGN: begin
                w_product_nxt  = w_full[OUT_WIDTH-1:0];
                w_overflow_nxt = ~((&w_upper) | ~(|w_upper));
                w_valid_nxt    = 1'b1;
                w_state_nxt    = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ma        <= '0;
            r_mb        <= '0;
            r_neg       <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_product   <= '0;
            r_overflow  <= 1'b0;
            r_valid_out <= 1'b0;
        end else begin
            r_ma        <= w_ma_nxt;
            r_mb        <= w_mb_nxt;
            r_neg       <= w_neg_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_product   <= w_product_nxt;
            r_overflow  <= w_overflow_nxt;
            r_valid_out <= w_valid_nxt;
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: an 8x8 instance with a 16-bit product and an 8x8
// instance with an 8-bit product share one stimulus stream.
module tb_seq_mult;

    logic       clk;
    logic       reset;
    logic       valid_in;
    logic [7:0] a;
    logic [7:0] b;

    logic        ready16, vo16, ov16;
    logic [15:0] prod16;
    logic        ready8, vo8, ov8;
    logic [7:0]  prod8;

    seq_mult #(.A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .multiplicand(a), .multiplier(b),
        .ready(ready16), .product(prod16), .valid_out(vo16), .overflow(ov16)
    );

    seq_mult #(.A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .multiplicand(a), .multiplier(b),
        .ready(ready8), .product(prod8), .valid_out(vo8), .overflow(ov8)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p16;
        logic        ov16;
        logic [7:0]  p8;
        logic        ov8;
    } vec_t;

    typedef struct {
        logic [15:0] p16;
        logic        ov16;
        logic [7:0]  p8;
        logic        ov8;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   last_vo = 0;
    int   prev_vo_cyc = 0;
    logic prev_vo16 = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Scoreboard monitor: pops one expectation per valid_out pulse.
    always @(negedge clk) begin
        exp_t e;
        if (reset && (vo16 || vo8)) begin
            if (sb.size() == 0) begin
                check("unexpected_valid_out", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("product16", 32'(prod16), 32'(e.p16));
                check("overflow16", 32'(ov16), 32'(e.ov16));
                check("product8", 32'(prod8), 32'(e.p8));
                check("overflow8", 32'(ov8), 32'(e.ov8));
                check("valid_out16", 32'(vo16), 32'd1);
                check("valid_out8", 32'(vo8), 32'd1);
                // Accept edge E0 -> valid_out seen on the 10th falling edge after E0.
                check("latency", 32'(cyc - e.acc_cyc), 32'd9);
                check("single_pulse", 32'(prev_vo16), 32'd0);
                prev_vo_cyc = last_vo;
                last_vo = cyc;
                n_out++;
            end
        end
        prev_vo16 = vo16;
    end

    // Drive one transaction (entered just after a falling edge) and record it.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [15:0] p16, input logic o16,
                        input logic [7:0] p8, input logic o8);
        int n = 0;
        a = ta;
        b = tb_v;
        valid_in = 1'b1;
        while (!ready16 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready16) begin
            check("ready_timeout", 32'(ready16), 32'd1);
        end else begin
            sb.push_back('{p16, o16, p8, o8, cyc + 1});
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        check("ready_low_after_accept", 32'(ready16), 32'd0);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin : main
        vec_t vecs[12];
        logic [7:0] ra, rb;
        logic signed [7:0] low8;
        int full;
        int c_first, c_second, n;

        vecs[0]  = '{8'd7,   8'd6,   16'd42,    1'b0, 8'd42,  1'b0};
        vecs[1]  = '{8'h80,  8'h80,  16'h4000,  1'b0, 8'h00,  1'b1};
        vecs[2]  = '{8'h80,  8'h7F,  16'hC080,  1'b0, 8'h80,  1'b1};
        vecs[3]  = '{8'd16,  8'd8,   16'h0080,  1'b0, 8'h80,  1'b1};
        vecs[4]  = '{8'hF8,  8'd16,  16'hFF80,  1'b0, 8'h80,  1'b0};
        vecs[5]  = '{8'd0,   8'hB3,  16'h0000,  1'b0, 8'h00,  1'b0};
        vecs[6]  = '{8'd3,   8'd5,   16'd15,    1'b0, 8'd15,  1'b0};
        vecs[7]  = '{8'hFE,  8'd9,   16'hFFEE,  1'b0, 8'hEE,  1'b0};
        vecs[8]  = '{8'h7F,  8'h7F,  16'h3F01,  1'b0, 8'h01,  1'b1};
        vecs[9]  = '{8'hFF,  8'hFF,  16'h0001,  1'b0, 8'h01,  1'b0};
        vecs[10] = '{8'h80,  8'd1,   16'hFF80,  1'b0, 8'h80,  1'b0};
        vecs[11] = '{8'd100, 8'hFD,  16'hFED4,  1'b0, 8'hD4,  1'b1};

        reset = 1'b0;
        valid_in = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("reset_product16", 32'(prod16), 32'd0);
        check("reset_overflow16", 32'(ov16), 32'd0);
        check("reset_valid_out", 32'(vo16), 32'd0);
        check("reset_ready", 32'(ready16), 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].p16, vecs[i].ov16, vecs[i].p8, vecs[i].ov8);
        end
        drain();
        repeat (5) @(negedge clk);
        check("product_holds", 32'(prod16), 32'h0000FED4);
        check("valid_out_idle", 32'(vo16), 32'd0);

        // Random operands against an integer-multiply model.
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            full = int'($signed(ra)) * int'($signed(rb));
            low8 = full[7:0];
            send(ra, rb, full[15:0], 1'b0, full[7:0], (full != int'(low8)));
        end
        drain();

        // Back-to-back with valid_in held high; operands changed during CALC.
        @(negedge clk);
        a = 8'd3;
        b = 8'd5;
        valid_in = 1'b1;
        check("b2b_ready_first", 32'(ready16), 32'd1);
        c_first = cyc + 1;
        sb.push_back('{16'd15, 1'b0, 8'd15, 1'b0, c_first});
        @(posedge clk);
        #1;
        a = 8'hFE;
        b = 8'd9;
        n = 0;
        @(negedge clk);
        while (!ready16 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_ready_with_valid_out", 32'(vo16), 32'd1);
        c_second = cyc + 1;
        sb.push_back('{16'hFFEE, 1'b0, 8'hEE, 1'b0, c_second});
        check("b2b_accept_spacing", 32'(c_second - c_first), 32'd10);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        @(negedge clk);
        drain();
        check("b2b_pulse_spacing", 32'(last_vo - prev_vo_cyc), 32'd10);

        // Reset in the fourth CALC cycle aborts the transaction.
        @(negedge clk);
        a = 8'd50;
        b = 8'd3;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_product16", 32'(prod16), 32'd0);
        check("abort_product8", 32'(prod8), 32'd0);
        check("abort_overflow8", 32'(ov8), 32'd0);
        check("abort_valid_out", 32'(vo16), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("ready_after_release", 32'(ready16), 32'd1);
        @(negedge clk);
        send(8'd2, 8'd2, 16'd4, 1'b0, 8'd4, 1'b0);
        drain();
        repeat (12) @(negedge clk);
        check("output_count", 32'(n_out), 32'd23);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
